// File: rtl/mem_bus_stage_if.sv
// Data-bus bundle between the MEM stage (master) and the memory/bus fabric (slave).
// A single req/ack transfer: cyc is held until ack is seen.
interface mem_bus_stage_if;
  logic        cyc;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output cyc, we, addr, sel, wdata, input rdata, ack);
  modport slave  (input cyc, we, addr, sel, wdata, output rdata, ack);
endinterface

// File: rtl/mem_bus_stage.sv
// MEM pipeline stage: passes non-memory ops through, runs loads/stores as one bus
// transfer each while holding the pipeline via stallreq_o. Big-endian byte lanes.
module mem_bus_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        whilo_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whilo_o,
  output logic        stallreq_o,
  output logic        align_err_o,
  mem_bus_stage_if.master bus
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [4:0] NOPRegAddr = 5'b00000;
  localparam logic       NoStop     = 1'b0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic        cyc_q, we_q;
  logic [31:0] addr_q, data_q, rdata_q;
  logic [3:0]  sel_q;

  logic        is_load, is_store, is_byte, is_half, is_word, sign_ext;
  logic        is_mem, misalign;
  logic [3:0]  sel_c;
  logic [31:0] store_c, load_c;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        unused_ok;

  assign unused_ok = ^{stall_i[5], stall_i[3:0]};

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    sign_ext = 1'b0;
    case (aluop_i)
      EXE_LB_OP:  begin is_load  = 1'b1; is_byte = 1'b1; sign_ext = 1'b1; end
      EXE_LBU_OP: begin is_load  = 1'b1; is_byte = 1'b1; end
      EXE_LH_OP:  begin is_load  = 1'b1; is_half = 1'b1; sign_ext = 1'b1; end
      EXE_LHU_OP: begin is_load  = 1'b1; is_half = 1'b1; end
      EXE_LW_OP:  begin is_load  = 1'b1; is_word = 1'b1; end
      EXE_SB_OP:  begin is_store = 1'b1; is_byte = 1'b1; end
      EXE_SH_OP:  begin is_store = 1'b1; is_half = 1'b1; end
      EXE_SW_OP:  begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
  end

  assign is_mem   = is_load | is_store;
  assign misalign = (is_half & mem_addr_i[0]) | (is_word & (mem_addr_i[1:0] != 2'b00));

  // Lane 3 (sel bit 3) carries bits 31:24, i.e. the lowest byte address.
  always_comb begin
    sel_c   = 4'b1111;
    store_c = reg2_i;
    if (is_byte) begin
      store_c = {4{reg2_i[7:0]}};
      case (mem_addr_i[1:0])
        2'd0:    sel_c = 4'b1000;
        2'd1:    sel_c = 4'b0100;
        2'd2:    sel_c = 4'b0010;
        default: sel_c = 4'b0001;
      endcase
    end else if (is_half) begin
      store_c = {2{reg2_i[15:0]}};
      sel_c   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
    end
  end

  // The EX/MEM register holds the instruction during the stall, so the live
  // address still selects the lane from the captured word in DONE.
  always_comb begin
    case (mem_addr_i[1:0])
      2'd0:    lane_b = rdata_q[31:24];
      2'd1:    lane_b = rdata_q[23:16];
      2'd2:    lane_b = rdata_q[15:8];
      default: lane_b = rdata_q[7:0];
    endcase
    lane_h = mem_addr_i[1] ? rdata_q[15:0] : rdata_q[31:16];
    if (is_byte)
      load_c = {{24{sign_ext & lane_b[7]}}, lane_b};
    else if (is_half)
      load_c = {{16{sign_ext & lane_h[15]}}, lane_h};
    else
      load_c = rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      sel_q   <= 4'h0;
      data_q  <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      case (state)
        IDLE: if (is_mem && !misalign) begin
          cyc_q  <= 1'b1;
          we_q   <= is_store;
          addr_q <= {mem_addr_i[31:2], 2'b00};
          sel_q  <= sel_c;
          data_q <= store_c;
          state  <= BUSY;
        end
        BUSY: if (bus.ack) begin
          rdata_q <= bus.rdata;
          cyc_q   <= 1'b0;
          we_q    <= 1'b0;
          state   <= DONE;
        end
        DONE: if (stall_i[4] == NoStop) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cyc   = cyc_q;
  assign bus.we    = we_q;
  assign bus.addr  = addr_q;
  assign bus.sel   = sel_q;
  assign bus.wdata = data_q;

  always_comb begin
    wd_o        = wd_i;
    wreg_o      = wreg_i;
    wdata_o     = wdata_i;
    hi_o        = hi_i;
    lo_o        = lo_i;
    whilo_o     = whilo_i;
    stallreq_o  = 1'b0;
    align_err_o = 1'b0;
    if (rst) begin
      wd_o    = NOPRegAddr;
      wreg_o  = 1'b0;
      wdata_o = 32'h0;
      hi_o    = 32'h0;
      lo_o    = 32'h0;
      whilo_o = 1'b0;
    end else begin
      case (state)
        IDLE: if (is_mem) begin
          if (misalign) begin
            wreg_o      = 1'b0;
            align_err_o = 1'b1;
          end else begin
            stallreq_o  = 1'b1;
          end
        end
        BUSY: stallreq_o = 1'b1;
        DONE: if (is_load) wdata_o = load_c;
        default: ;
      endcase
      if (is_store) wreg_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_bus_stage.sv
// Directed bench for mem_bus_stage: pass-through, loads/stores with varying ack
// latency, misalignment, mid-transfer reset and downstream stall in DONE.
module tb_mem_bus_stage;

  localparam logic [7:0] OP_OR  = 8'b0010_0101;
  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;
  localparam logic [31:0] HI_K  = 32'hA5A5_0001;
  localparam logic [31:0] LO_K  = 32'h5A5A_0002;

  logic clk = 1'b0;
  logic rst;
  logic [5:0]  stall_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i, hi_i, lo_i, mem_addr_i, reg2_i;
  logic        whilo_i;
  logic [7:0]  aluop_i;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, stallreq_o, align_err_o;
  logic [31:0] wdata_o, hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  mem_bus_stage_if bus_if ();

  mem_bus_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i),
    .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o),
    .stallreq_o(stallreq_o), .align_err_o(align_err_o),
    .bus(bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs an aligned access from IDLE until stallreq drops (DONE). Ack is raised
  // on BUSY cycle number ack_wait (0 = first BUSY cycle).
  task automatic access(input int ack_wait, output int stalls, output logic [3:0] sel,
                        output logic [31:0] addr, output logic [31:0] wdat,
                        output logic we, output logic wreg_seen);
    int busy = 0;
    logic done = 1'b0;
    stalls = 0; sel = 'x; addr = 'x; wdat = 'x; we = 'x; wreg_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!stallreq_o) begin
        done = 1'b1;
        break;
      end
      stalls++;
      wreg_seen = wreg_seen | (wreg_o & (aluop_i[3] == 1'b1));
      if (bus_if.cyc) begin
        if (busy == 0) begin
          sel = bus_if.sel; addr = bus_if.addr; wdat = bus_if.wdata; we = bus_if.we;
        end
        if (busy == ack_wait) bus_if.ack = 1'b1;
        busy++;
      end
      @(posedge clk);
      #1;
      bus_if.ack = 1'b0;
      chk("hi_pass_stall", hi_o, HI_K);
    end
    chk("access_done", {31'b0, done}, 32'd1);
  endtask

  task automatic set_nop();
    aluop_i = OP_OR; wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h0;
    mem_addr_i = 32'h0; reg2_i = 32'h0;
  endtask

  int stalls;
  logic [3:0] sel;
  logic [31:0] addr, wdat;
  logic we, wreg_seen;

  initial begin
    rst = 1'b1; stall_i = 6'b0; whilo_i = 1'b1;
    hi_i = HI_K; lo_i = LO_K;
    aluop_i = OP_OR; wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h1234;
    mem_addr_i = 32'h0; reg2_i = 32'h0;
    bus_if.ack = 1'b0; bus_if.rdata = 32'h0;
    #22;
    chk("rst_wd", {27'b0, wd_o}, 32'd0);
    chk("rst_wreg", {31'b0, wreg_o}, 32'd0);
    chk("rst_wdata", wdata_o, 32'h0);
    chk("rst_hi", hi_o, 32'h0);
    chk("rst_whilo", {31'b0, whilo_o}, 32'd0);
    chk("rst_cyc", {31'b0, bus_if.cyc}, 32'd0);
    chk("rst_addr", bus_if.addr, 32'h0);
    chk("rst_sel", {28'b0, bus_if.sel}, 32'd0);
    rst = 1'b0;

    // Non-memory pass-through
    #1;
    chk("alu_wd", {27'b0, wd_o}, 32'd5);
    chk("alu_wdata", wdata_o, 32'h1234);
    chk("alu_wreg", {31'b0, wreg_o}, 32'd1);
    chk("alu_lo", lo_o, LO_K);
    chk("alu_stall", {31'b0, stallreq_o}, 32'd0);
    tick();
    chk("alu_cyc", {31'b0, bus_if.cyc}, 32'd0);

    // LB, ack in first BUSY cycle
    aluop_i = OP_LB; wd_i = 5'd7; wreg_i = 1'b1; mem_addr_i = 32'h1001;
    bus_if.rdata = 32'h0080_0000;
    access(0, stalls, sel, addr, wdat, we, wreg_seen);
    chk("lb_stalls", stalls, 32'd2);
    chk("lb_sel", {28'b0, sel}, 32'b0100);
    chk("lb_addr", addr, 32'h1000);
    chk("lb_we", {31'b0, we}, 32'd0);
    chk("lb_wdata", wdata_o, 32'hFFFF_FF80);
    chk("lb_wreg", {31'b0, wreg_o}, 32'd1);
    chk("lb_done_cyc", {31'b0, bus_if.cyc}, 32'd0);
    tick(); set_nop();

    // LBU same address/data
    aluop_i = OP_LBU; wd_i = 5'd7; wreg_i = 1'b1; mem_addr_i = 32'h1001;
    access(0, stalls, sel, addr, wdat, we, wreg_seen);
    chk("lbu_stalls", stalls, 32'd2);
    chk("lbu_wdata", wdata_o, 32'h0000_0080);
    tick(); set_nop();

    // SH, ack three cycles late
    aluop_i = OP_SH; wd_i = 5'd9; wreg_i = 1'b1; mem_addr_i = 32'h2002; reg2_i = 32'hDEAD_BEEF;
    access(3, stalls, sel, addr, wdat, we, wreg_seen);
    chk("sh_stalls", stalls, 32'd5);
    chk("sh_we", {31'b0, we}, 32'd1);
    chk("sh_sel", {28'b0, sel}, 32'b0011);
    chk("sh_addr", addr, 32'h2000);
    chk("sh_data", wdat, 32'hBEEF_BEEF);
    chk("sh_wreg_stall", {31'b0, wreg_seen}, 32'd0);
    chk("sh_wreg_done", {31'b0, wreg_o}, 32'd0);
    chk("sh_we_cleared", {31'b0, bus_if.we}, 32'd0);
    tick(); set_nop();

    // SB replicates the byte into every lane
    aluop_i = OP_SB; mem_addr_i = 32'h6003; reg2_i = 32'h1234_56A5; wreg_i = 1'b1;
    access(1, stalls, sel, addr, wdat, we, wreg_seen);
    chk("sb_stalls", stalls, 32'd3);
    chk("sb_sel", {28'b0, sel}, 32'b0001);
    chk("sb_data", wdat, 32'hA5A5_A5A5);
    tick(); set_nop();

    // Misaligned LW
    aluop_i = OP_LW; wd_i = 5'd3; wreg_i = 1'b1; mem_addr_i = 32'h3002;
    #1;
    chk("mis_err", {31'b0, align_err_o}, 32'd1);
    chk("mis_stall", {31'b0, stallreq_o}, 32'd0);
    chk("mis_wreg", {31'b0, wreg_o}, 32'd0);
    tick();
    chk("mis_cyc", {31'b0, bus_if.cyc}, 32'd0);
    set_nop(); #1;
    chk("mis_err_pulse", {31'b0, align_err_o}, 32'd0);
    chk("mis_idle_stall", {31'b0, stallreq_o}, 32'd0);

    // Reset in the middle of an SW
    aluop_i = OP_SW; mem_addr_i = 32'h4008; reg2_i = 32'hCAFE_F00D;
    tick();
    chk("sw_busy_cyc", {31'b0, bus_if.cyc}, 32'd1);
    #2 rst = 1'b1; #1;
    chk("rst_mid_cyc", {31'b0, bus_if.cyc}, 32'd0);
    chk("rst_mid_stall", {31'b0, stallreq_o}, 32'd0);
    tick();
    set_nop(); #2 rst = 1'b0;
    bus_if.ack = 1'b1;
    tick();
    bus_if.ack = 1'b0;
    chk("late_ack_cyc", {31'b0, bus_if.cyc}, 32'd0);
    chk("late_ack_stall", {31'b0, stallreq_o}, 32'd0);
    aluop_i = OP_LW; wd_i = 5'd4; wreg_i = 1'b1; mem_addr_i = 32'h4000;
    bus_if.rdata = 32'h1122_3344;
    access(0, stalls, sel, addr, wdat, we, wreg_seen);
    chk("lw_stalls", stalls, 32'd2);
    chk("lw_sel", {28'b0, sel}, 32'b1111);
    chk("lw_wdata", wdata_o, 32'h1122_3344);
    tick(); set_nop();

    // LH held in DONE by a downstream stall
    aluop_i = OP_LH; wd_i = 5'd6; wreg_i = 1'b1; mem_addr_i = 32'h5002;
    bus_if.rdata = 32'h0000_8001;
    access(0, stalls, sel, addr, wdat, we, wreg_seen);
    chk("lh_wdata", wdata_o, 32'hFFFF_8001);
    stall_i = 6'b01_1111; bus_if.rdata = 32'h7777_7777;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("hold_cyc", {31'b0, bus_if.cyc}, 32'd0);
      chk("hold_stall", {31'b0, stallreq_o}, 32'd0);
      chk("hold_wdata", wdata_o, 32'hFFFF_8001);
    end
    stall_i = 6'b0;
    tick(); set_nop(); #1;
    chk("hold_exit_cyc", {31'b0, bus_if.cyc}, 32'd0);
    chk("hold_exit_wdata", wdata_o, 32'h0);
    tick();
    chk("idle_cyc", {31'b0, bus_if.cyc}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
